param_counter: RTL

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/param_counter.sv
// param_counter: modulo-N up/down counter with programmable step, clamped
// synchronous load, one-cycle terminal-count pulse and sticky overflow flag.
// Optional build macro PARAM_COUNTER_SAT_EN: when defined, a step that would
// wrap instead sticks at MODULO-1 (up) or 0 (down); tc/ovf still report it.
// Priority per edge: clr > load > en > hold. Reset is asynchronous, active-low.
module param_counter #(
  parameter int WIDTH  = 7,
  parameter int MODULO = 100,
  parameter int STEP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  // One extra bit keeps cur+STEP and cur+MODULO exact even at MODULO=2**WIDTH.
  localparam logic [WIDTH:0] MOD_V  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0] STEP_V = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MAX_V  = (WIDTH+1)'(MODULO - 1);

  generate
    if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
      $error("param_counter: MODULO out of range for WIDTH");
    end
    if (STEP < 1 || STEP >= MODULO) begin : g_bad_step
      $error("param_counter: STEP must satisfy 1 <= STEP < MODULO");
    end
  endgenerate

  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   inc;
  logic             up_wrap;
  logic             dn_wrap;
  logic             bnd;
  logic [WIDTH:0]   step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             step_unused;

  assign cur     = {1'b0, out};
  assign inc     = cur + STEP_V;
  assign up_wrap = (inc >= MOD_V);
  assign dn_wrap = (cur < STEP_V);
  assign bnd     = up ? up_wrap : dn_wrap;

  // Next count for an enabled step: wrap by default, or pin at the end stop.
  always_comb begin
    step_val = cur;
`ifdef PARAM_COUNTER_SAT_EN
    if (up) step_val = up_wrap ? MAX_V : inc;
    else    step_val = dn_wrap ? '0    : cur - STEP_V;
`else
    if (up) step_val = up_wrap ? inc - MOD_V        : inc;
    else    step_val = dn_wrap ? cur + MOD_V - STEP_V : cur - STEP_V;
`endif
  end

  // Out-of-range load values are clamped to the top of the count range.
  always_comb begin
    load_clamped = load_val;
    if ({1'b0, load_val} >= MOD_V) load_clamped = MAX_V[WIDTH-1:0];
  end

  // In range the top bit of step_val is always zero; it is only carry room.
  assign step_unused = step_val[WIDTH];

  // Count/flag registers: clr beats load beats en; tc lasts one cycle only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      out <= load_clamped;
      tc  <= 1'b0;
    end else if (en) begin
      out <= step_val[WIDTH-1:0];
      tc  <= bnd;
      ovf <= ovf | bnd;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule
